// File: rtl/result_trace_buffer.sv
// Commit trace FIFO: stamps each retired write/branch with a sequence
// number and exposes it first-word-fall-through over valid/ready.
module result_trace_buffer #(
  parameter int Data_W = 32,
  parameter int Depth  = 16,
  parameter int Seq_W  = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic                       Clear,
  input  logic                       RegWrite,
  input  logic                       MemWrite,
  input  logic                       PCSrc,
  input  logic [3:0]                 Rd,
  input  logic [Data_W-1:0]          Result_In,
  output logic                       Trace_Valid,
  input  logic                       Trace_Ready,
  output logic [Seq_W+6+Data_W-1:0]  Trace_Data,
  output logic [$clog2(Depth):0]     Count,
  output logic                       Full,
  output logic [15:0]                Overflow_Count
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int EW = Seq_W + 6 + Data_W;

  logic [EW-1:0]    mem [Depth];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [Seq_W-1:0] seq;
  logic [1:0]       ev_type;
  logic             ev;
  logic             pop;
  logic             push;

  always_comb begin
    ev_type = 2'b00;
    priority case (1'b1)
      PCSrc:    ev_type = 2'b10;
      MemWrite: ev_type = 2'b01;
      default:  ev_type = 2'b00;
    endcase
  end

  assign ev   = Enable & (RegWrite | MemWrite | PCSrc);
  assign pop  = Trace_Valid & Trace_Ready;
  // A full FIFO still takes the event if the head leaves at the same edge
  assign push = ev & (~Full | pop);

  assign Trace_Valid = (Count != '0);
  assign Full        = (Count == CW'(Depth));
  assign Trace_Data  = Trace_Valid ? mem[rd_ptr] : '0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      Count          <= '0;
      seq            <= '0;
      Overflow_Count <= '0;
    end else if (Clear) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      Count          <= '0;
      seq            <= '0;
      Overflow_Count <= '0;
    end else begin
      if (ev)
        seq <= seq + Seq_W'(1);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (ev && !push && Overflow_Count != 16'hFFFF)
        Overflow_Count <= Overflow_Count + 16'd1;
      unique case ({push, pop})
        2'b10:   Count <= Count + CW'(1);
        2'b01:   Count <= Count - CW'(1);
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push && !Clear)
      mem[wr_ptr] <= {seq, ev_type, Rd, Result_In};
  end

endmodule

// File: doc/result_trace_buffer.md
Name: result_trace_buffer

Overview:
- Sits directly downstream of the single-cycle datapath.
- Each cycle it watches the committed Result and the architectural write/branch strobes from the controller.
- It tags every commit event with a sequence number and queues it in a first-word-fall-through FIFO.
- A debug host or UART bridge drains the FIFO over a valid/ready handshake, which makes retired-instruction effects observable in silicon without stalling the core.

Parameters:
- Data_W, 32: width of the captured Result.
- Depth, 16: number of FIFO entries. Must be a power of two, minimum 2.
- Seq_W, 8: width of the sequence stamp.

Ports:
- Clock  input  1  rising-edge clock, shared with the datapath.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  capture enable. While low, no events are captured and Seq does not advance.
- Clear  input  1  synchronous flush of the FIFO, Seq and Overflow_Count. Has priority over all other actions.
- RegWrite  input  1  register-file write strobe of the current instruction.
- MemWrite  input  1  data-memory write strobe of the current instruction.
- PCSrc  input  1  PC loaded from Result (branch or write to R15).
- Rd  input  4  destination register field of the current instruction.
- Result_In  input  Data_W  datapath Result_Out.
- Trace_Valid  output  1  head entry is available (FIFO not empty).
- Trace_Ready  input  1  consumer accepts the head entry.
- Trace_Data  output  Seq_W+6+Data_W  head entry, packed as {Seq, Type[1:0], Rd[3:0], Result}.
- Count  output  log2(Depth)+1  current occupancy.
- Full  output  1  Count == Depth.
- Overflow_Count  output  16  number of dropped events, saturating.

Behaviour:
- Reset (Reset low, asynchronous):
  - Read and write pointers, Count, Seq and Overflow_Count are all 0.
  - Trace_Valid = 0 and Full = 0.
  - Trace_Data = 0 while empty.
  - Memory contents are don't-care.
- Reset deassertion: outputs hold their reset values until the first capturing edge. Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Event definition: event = Enable & (RegWrite | MemWrite | PCSrc), sampled at the rising edge.
- Type encoding, in priority order:
  - PCSrc → 2'b10.
  - else MemWrite → 2'b01.
  - else 2'b00 (register write).
  - 2'b11 is reserved and never produced.
- Entry fields:
  - Rd is captured as-is for every type, including memory writes.
  - Result is Result_In at that edge.
  - Seq is the value of the Seq counter before it increments.
- Seq advances by 1 on every event, whether accepted or dropped. It wraps from 2^Seq_W−1 to 0. A gap in Seq at the consumer therefore means events were lost.
- Pop: occurs at an edge when Trace_Valid & Trace_Ready. The read pointer advances; Trace_Data changes to the next entry after the edge.
- FWFT behaviour:
  - Trace_Data = mem[rd_ptr] whenever Trace_Valid = 1.
  - An event captured at edge N raises Trace_Valid after edge N, giving one-cycle latency.
  - The head entry and Trace_Valid stay stable while Trace_Ready is low.
- Push when not full: the entry is written at wr_ptr and the write pointer advances. Pointers wrap modulo Depth.
- Push when full:
  - With a pop at the same edge: the push is accepted, Count is unchanged and Full stays 1.
  - Without a pop: the event is dropped and Overflow_Count increments, saturating at 16'hFFFF.
- Push and pop at the same edge when not full and not empty: Count is unchanged and both pointers advance.
- Empty with push and Trace_Ready high: no pop occurs, because Trace_Valid was 0. The push is accepted and Count becomes 1.
- Count updates at each edge: +1 for push only, −1 for pop only, unchanged for both or neither.
- Clear at an edge:
  - Pointers, Count, Seq and Overflow_Count go to 0.
  - Any simultaneous event or pop is ignored.
  - Trace_Valid is 0 after the edge.
- Trace_Data, Count, Full and Overflow_Count are all driven from registers or from memory indexed by a registered pointer. No combinational path exists from the event inputs to any output.

Test Plan:
- Reset low, then high. Pulse RegWrite=1, Rd=3, Result_In=32'h0000_00AA for one cycle with Enable=1 and Trace_Ready=0 → after that edge Trace_Valid=1, Trace_Data={8'h00,2'b00,4'h3,32'hAA}, Count=1.
- Hold Trace_Ready=0 and issue 20 events with Depth=16 → Count=16, Full=1, Overflow_Count=4. Then drain with Trace_Ready=1 → Seq values 0..15 appear in order, then Trace_Valid=0.
- Keep the FIFO full and assert Trace_Ready=1 while MemWrite=1, Result_In=32'h1234 → Count stays 16, Overflow_Count unchanged, and the new tail entry has Type=01.
- PCSrc=1 and RegWrite=1 in the same cycle → Type=10. Enable=0 with RegWrite=1 → no entry is queued and Seq is unchanged.
- Issue 300 events while draining continuously → Seq wraps 8'hFF→8'h00 without gaps, and Overflow_Count=0.
- Fill 5 entries, then drop Reset low for less than a full clock period → Count=0 and Trace_Valid=0 immediately, and Overflow_Count=0. Repeat with Clear=1 plus a simultaneous event → FIFO empty, Seq=0.
